// File: rtl/dm_sba_bus_master_pkg.sv
// Shared types for the SBA bus master: FSM state, sberror codes, sbaccess size codes
// and the alignment helper used by the trigger checks.
package dm_sba_bus_master_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } sba_state_e;

    typedef enum logic [2:0] {
        SbErrNone    = 3'd0,
        SbErrTimeout = 3'd1,
        SbErrBadAddr = 3'd2,
        SbErrAlign   = 3'd3,
        SbErrSize    = 3'd4
    } sberror_e;

    typedef enum logic [2:0] {
        SbAccess8  = 3'd0,
        SbAccess16 = 3'd1,
        SbAccess32 = 3'd2
    } sbaccess_e;

    // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic is_misaligned(logic [1:0] off, logic [2:0] size);
        return ((size == SbAccess16) && off[0]) || ((size == SbAccess32) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dm_sba_bus_master_if.sv
// Request/grant/rvalid system bus between the SBA master and the memory system.
//   req/we/addr/be/wdata : request side, driven by the master
//   gnt                  : request accepted
//   rvalid/rdata/err     : response; err is only meaningful with rvalid
interface dm_sba_bus_master_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dm_sba_lane_align.sv
// Combinational byte-lane steering for 8/16/32-bit accesses on a 32-bit bus.
//   offset, size   : byte offset within the word and sbaccess size code
//   wdata_in       : unaligned write data (sbdata0)
//   rdata_in       : raw bus read data
//   be, wdata      : byte enables and lane-replicated write data
//   rdata          : read data shifted down to bit 0 and zero-extended to the size
module dm_sba_lane_align
    import dm_sba_bus_master_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_in >> {offset, 3'b000};
        be      = 4'b1111;
        wdata   = wdata_in;
        rdata   = shifted;
        case (size)
            SbAccess8: begin
                be    = 4'b0001 << offset;
                wdata = {4{wdata_in[7:0]}};
                rdata = {24'h0, shifted[7:0]};
            end
            SbAccess16: begin
                be    = 4'b0011 << offset;
                wdata = {2{wdata_in[15:0]}};
                rdata = {16'h0, shifted[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/dm_sba_bus_master.sv
// SBA bus master: turns sbcs/sbaddress/sbdata triggers from the register block into single
// 8/16/32-bit accesses on a req/gnt/rvalid bus and returns data, errors, busy and the
// auto-incremented address. All outputs are flops.
//   sb*_i / *_valid_i : register-block fields and trigger pulses
//   sb*_o / *_valid_o : results and one-cycle update strobes back to the register block
//   bus               : system bus master port
module dm_sba_bus_master
    import dm_sba_bus_master_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [31:0]                sbaddress_i,
    input  logic [31:0]                sbdata_i,
    input  logic [2:0]                 sbaccess_i,
    input  logic                       sbautoincrement_i,
    input  logic                       sbreadonaddr_i,
    input  logic                       sbreadondata_i,
    input  logic                       sbaddress_write_valid_i,
    input  logic                       sbdata_read_valid_i,
    input  logic                       sbdata_write_valid_i,
    output logic [31:0]                sbaddress_o,
    output logic                       sbaddress_valid_o,
    output logic [31:0]                sbdata_o,
    output logic                       sbdata_valid_o,
    output logic [2:0]                 sberror_o,
    output logic                       sberror_valid_o,
    output logic                       sbbusy_o,
    dm_sba_bus_master_if.master        bus
);
    sba_state_e  state_q, state_d;
    logic [31:0] addr_q, sbaddress_q, sbaddress_d, sbdata_q, sbdata_d, wdata_q;
    logic [1:0]  size_q;
    logic [3:0]  be_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  sberror_q, sberror_d;
    logic        we_q, req_q, req_d, busy_q, latch;
    logic        sbaddress_valid_q, sbaddress_valid_d, sbdata_valid_q, sbdata_valid_d;
    logic        sberror_valid_q, sberror_valid_d;
    logic        trig_write, trig_read, timeout;
    logic [1:0]  align_off;
    logic [2:0]  align_size;
    logic [3:0]  align_be;
    logic [31:0] align_wdata, align_rdata;

    assign trig_write = sbdata_write_valid_i;
    assign trig_read  = (sbaddress_write_valid_i && sbreadonaddr_i) ||
                        (sbdata_read_valid_i && sbreadondata_i);
    assign timeout    = ({1'b0, cnt_q} + 9'd1) == 9'(TimeoutCycles);

    // In IDLE the aligner sees the trigger inputs (to register be/wdata for the request);
    // once busy it sees the latched access (to steer the read response).
    assign align_off  = (state_q == StIdle) ? sbaddress_i[1:0] : addr_q[1:0];
    assign align_size = (state_q == StIdle) ? sbaccess_i : {1'b0, size_q};

    dm_sba_lane_align u_lane_align (
        .offset   (align_off),
        .size     (align_size),
        .wdata_in (sbdata_i),
        .rdata_in (bus.rdata),
        .be       (align_be),
        .wdata    (align_wdata),
        .rdata    (align_rdata)
    );

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        req_d             = req_q;
        latch             = 1'b0;
        sbaddress_d       = sbaddress_q;
        sbdata_d          = sbdata_q;
        sberror_d         = sberror_q;
        sbaddress_valid_d = 1'b0;
        sbdata_valid_d    = 1'b0;
        sberror_valid_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Stray rvalid here belongs to a timed-out access and is dropped.
                if (trig_write || trig_read) begin
                    if (sbaccess_i > SbAccess32) begin
                        sberror_valid_d = 1'b1;
                        sberror_d       = SbErrSize;
                    end else if (is_misaligned(sbaddress_i[1:0], sbaccess_i)) begin
                        sberror_valid_d = 1'b1;
                        sberror_d       = SbErrAlign;
                    end else begin
                        latch   = 1'b1;
                        state_d = StReq;
                        req_d   = 1'b1;
                        cnt_d   = 8'd0;
                    end
                end
            end
            StReq: begin
                if (bus.gnt) begin
                    state_d = StResp;
                    req_d   = 1'b0;
                    cnt_d   = 8'd0;
                end else if (timeout) begin
                    state_d         = StIdle;
                    req_d           = 1'b0;
                    sberror_valid_d = 1'b1;
                    sberror_d       = SbErrTimeout;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                if (bus.rvalid) begin
                    state_d = StIdle;
                    if (bus.err) begin
                        sberror_valid_d = 1'b1;
                        sberror_d       = SbErrBadAddr;
                    end else begin
                        if (!we_q) begin
                            sbdata_valid_d = 1'b1;
                            sbdata_d       = align_rdata;
                        end
                        if (sbautoincrement_i) begin
                            sbaddress_valid_d = 1'b1;
                            sbaddress_d       = addr_q + (32'd1 << size_q);
                        end
                    end
                end else if (timeout) begin
                    state_d         = StIdle;
                    sberror_valid_d = 1'b1;
                    sberror_d       = SbErrTimeout;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= StIdle;
            addr_q            <= 32'h0;
            size_q            <= 2'd0;
            we_q              <= 1'b0;
            be_q              <= 4'h0;
            wdata_q           <= 32'h0;
            cnt_q             <= 8'd0;
            req_q             <= 1'b0;
            busy_q            <= 1'b0;
            sbaddress_q       <= 32'h0;
            sbdata_q          <= 32'h0;
            sberror_q         <= 3'd0;
            sbaddress_valid_q <= 1'b0;
            sbdata_valid_q    <= 1'b0;
            sberror_valid_q   <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            req_q             <= req_d;
            busy_q            <= (state_d != StIdle);
            sbaddress_q       <= sbaddress_d;
            sbdata_q          <= sbdata_d;
            sberror_q         <= sberror_d;
            sbaddress_valid_q <= sbaddress_valid_d;
            sbdata_valid_q    <= sbdata_valid_d;
            sberror_valid_q   <= sberror_valid_d;
            if (latch) begin
                addr_q  <= sbaddress_i;
                size_q  <= sbaccess_i[1:0];
                we_q    <= trig_write;
                be_q    <= align_be;
                wdata_q <= align_wdata;
            end
        end
    end

    assign bus.req           = req_q;
    assign bus.we            = we_q;
    assign bus.addr          = {addr_q[31:2], 2'b00};
    assign bus.be            = be_q;
    assign bus.wdata         = wdata_q;
    assign sbaddress_o       = sbaddress_q;
    assign sbaddress_valid_o = sbaddress_valid_q;
    assign sbdata_o          = sbdata_q;
    assign sbdata_valid_o    = sbdata_valid_q;
    assign sberror_o         = sberror_q;
    assign sberror_valid_o   = sberror_valid_q;
    assign sbbusy_o          = busy_q;
endmodule
